// File: rtl/parking_occupancy_controller.sv
// Parking lot occupancy counter with per-gate CLOSED/OPEN/HOLD barrier control.
// Optional forced close of a gate left open too long: define GATE_TIMEOUT_EN.
module parking_occupancy_controller #(
  parameter int unsigned CAPACITY     = 8,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned CLOSE_DELAY  = 3,
  parameter int unsigned GATE_TIMEOUT = 50
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_entry_sensor,
  input  logic             i_exit_sensor,
  input  logic             i_entry_passed,
  input  logic             i_exit_passed,
  input  logic             i_clear_err,
  output logic             o_entry_gate_open,
  output logic             o_exit_gate_open,
  output logic [CNT_W-1:0] o_occupancy,
  output logic [CNT_W-1:0] o_spaces_free,
  output logic             o_lot_full,
  output logic             o_lot_empty,
  output logic             o_err_overflow,
  output logic             o_err_underflow,
  output logic             o_err_timeout
);

  typedef enum logic [1:0] {
    StClosed = 2'd0,
    StOpen   = 2'd1,
    StHold   = 2'd2
  } gate_state_e;

  localparam int unsigned HoldW = (CLOSE_DELAY > 1) ? $clog2(CLOSE_DELAY) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(CLOSE_DELAY - 1);
  localparam logic [CNT_W-1:0] CapW = CNT_W'(CAPACITY);

  // Gate index 0 is the entry barrier, index 1 the exit barrier.
  logic [1:0] w_sensor;
  logic [1:0] w_passed;
  logic [1:0] w_allow;
  logic [1:0] w_timeout;

  gate_state_e      r_state         [2];
  gate_state_e      w_state_next    [2];
  logic [HoldW-1:0] r_hold_cnt      [2];
  logic [HoldW-1:0] w_hold_cnt_next [2];

  logic [CNT_W-1:0] r_occupancy;
  logic [CNT_W-1:0] w_occupancy_next;
  logic             w_lot_full;
  logic             w_lot_empty;
  logic             w_set_overflow;
  logic             w_set_underflow;
  logic             r_err_overflow;
  logic             r_err_underflow;

`ifdef GATE_TIMEOUT_EN
  localparam int unsigned ToW = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(GATE_TIMEOUT - 1);

  logic [ToW-1:0] r_to_cnt      [2];
  logic [ToW-1:0] w_to_cnt_next [2];
  logic           r_err_timeout;
`endif

  assign w_lot_full  = (r_occupancy == CapW);
  assign w_lot_empty = (r_occupancy == '0);

  assign w_sensor = {i_exit_sensor, i_entry_sensor};
  assign w_passed = {i_exit_passed, i_entry_passed};
  // The exit barrier is never blocked; entry waits for a free space.
  assign w_allow  = {1'b1, ~w_lot_full};

  always_comb begin
    w_timeout = '0;
    for (int g = 0; g < 2; g++) begin
      w_state_next[g]    = r_state[g];
      w_hold_cnt_next[g] = r_hold_cnt[g];
`ifdef GATE_TIMEOUT_EN
      w_to_cnt_next[g]   = r_to_cnt[g];
`endif
      unique case (r_state[g])
        StClosed: begin
          if (w_sensor[g] && w_allow[g]) begin
            w_state_next[g]  = StOpen;
`ifdef GATE_TIMEOUT_EN
            w_to_cnt_next[g] = '0;
`endif
          end
        end
        StOpen: begin
          if (w_passed[g]) begin
            w_state_next[g]    = StHold;
            w_hold_cnt_next[g] = HoldLoad;
          end
`ifdef GATE_TIMEOUT_EN
          else if (r_to_cnt[g] == ToLast) begin
            w_state_next[g] = StClosed;
            w_timeout[g]    = 1'b1;
          end else begin
            w_to_cnt_next[g] = r_to_cnt[g] + 1'b1;
          end
`endif
        end
        StHold: begin
          if (r_hold_cnt[g] == '0) begin
            w_state_next[g] = StClosed;
          end else begin
            w_hold_cnt_next[g] = r_hold_cnt[g] - 1'b1;
          end
        end
        default: w_state_next[g] = StClosed;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!i_reset_n) begin
        r_state[g]    <= StClosed;
        r_hold_cnt[g] <= '0;
      end else begin
        r_state[g]    <= w_state_next[g];
        r_hold_cnt[g] <= w_hold_cnt_next[g];
      end
    end
  end

`ifdef GATE_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!i_reset_n) begin
        r_to_cnt[g] <= '0;
      end else begin
        r_to_cnt[g] <= w_to_cnt_next[g];
      end
    end
  end
`endif

  // Simultaneous entry and exit cancel out and never flag an error.
  always_comb begin
    w_occupancy_next = r_occupancy;
    w_set_overflow   = 1'b0;
    w_set_underflow  = 1'b0;
    if (i_entry_passed && !i_exit_passed) begin
      if (w_lot_full) begin
        w_set_overflow = 1'b1;
      end else begin
        w_occupancy_next = r_occupancy + 1'b1;
      end
    end else if (i_exit_passed && !i_entry_passed) begin
      if (w_lot_empty) begin
        w_set_underflow = 1'b1;
      end else begin
        w_occupancy_next = r_occupancy - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_occupancy     <= '0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_occupancy     <= w_occupancy_next;
      r_err_overflow  <= (r_err_overflow & ~i_clear_err) | w_set_overflow;
      r_err_underflow <= (r_err_underflow & ~i_clear_err) | w_set_underflow;
    end
  end

`ifdef GATE_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= (r_err_timeout & ~i_clear_err) | (|w_timeout);
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  assign o_err_timeout = 1'b0;
`endif

  assign o_entry_gate_open = (r_state[0] != StClosed);
  assign o_exit_gate_open  = (r_state[1] != StClosed);
  assign o_occupancy       = r_occupancy;
  assign o_spaces_free     = CapW - r_occupancy;
  assign o_lot_full        = w_lot_full;
  assign o_lot_empty       = w_lot_empty;
  assign o_err_overflow    = r_err_overflow;
  assign o_err_underflow   = r_err_underflow;

endmodule

// File: doc/parking_occupancy_controller.md
# parking_occupancy_controller

Downstream consumer of the sensor interface stage: takes the debounced entry/exit sensor levels and the one-cycle entry_passed/exit_passed pulses, and maintains the lot occupancy count. Runs one open/hold/close state machine per barrier gate. Reports full/empty status and sticky error flags. Sits between sensor conditioning and the display/billing logic.

## Interface
- Clocking: one clock; reset is synchronous and active-low.

Parameters:
- CAPACITY, 8: number of parking spaces; legal range 1..(2^CNT_W − 1).
- CNT_W, 4: width of the occupancy and spaces_free counters.
- CLOSE_DELAY, 3: cycles a gate stays open after the pass pulse; must be ≥1.
- GATE_TIMEOUT, 50: maximum cycles in OPEN before a forced close. Used only with GATE_TIMEOUT_EN.

Ports:
- clk, input, 1: system clock, rising edge.
- reset_n, input, 1: synchronous reset, active low.
- entry_sensor, input, 1: debounced entry presence level.
- exit_sensor, input, 1: debounced exit presence level.
- entry_passed, input, 1: one-cycle pulse; a vehicle has entered.
- exit_passed, input, 1: one-cycle pulse; a vehicle has left.
- clear_err, input, 1: clears all sticky error flags.
- entry_gate_open, output, 1: entry barrier raise command.
- exit_gate_open, output, 1: exit barrier raise command.
- occupancy, output, CNT_W: vehicles currently in the lot.
- spaces_free, output, CNT_W: CAPACITY − occupancy.
- lot_full, output, 1: occupancy == CAPACITY.
- lot_empty, output, 1: occupancy == 0.
- err_overflow, output, 1: sticky; an entry pulse arrived while full.
- err_underflow, output, 1: sticky; an exit pulse arrived while empty.
- err_timeout, output, 1: sticky; a gate was force-closed (stays 0 without GATE_TIMEOUT_EN).

## Operation
- Occupancy register, updated on each clock edge:
  - entry_passed only: +1.
  - exit_passed only: −1.
  - Both in the same cycle: unchanged, and no error raised.
  - Entry pulse while occupancy == CAPACITY: count saturates and err_overflow is set.
  - Exit pulse while occupancy == 0: count stays 0 and err_underflow is set.
- Pass pulses are counted regardless of gate state, so tailgating is still counted.
- Each gate has a state machine with states CLOSED, OPEN and HOLD:
  - CLOSED → OPEN: when the sensor is high. For the entry gate this also requires !lot_full, evaluated from the registered occupancy in the same cycle. The exit gate is never blocked.
  - OPEN → HOLD: on the gate's passed pulse.
  - HOLD: a down-counter is loaded with CLOSE_DELAY−1 on entry to HOLD. The gate goes HOLD → CLOSED when the counter reaches 0.
  - A passed pulse during HOLD has no effect on the state machine.
  - The gate_open output is high in OPEN and HOLD (Moore output).
- A sensor held high while the entry gate is blocked by lot_full leaves the gate CLOSED. The gate opens on the first cycle lot_full drops while the sensor is still high.
- Error flags:
  - clear_err clears all flags.
  - If clear_err and a new error event occur in the same cycle, the set wins.

## Timing
- Reset values: both gates CLOSED, all outputs 0 except lot_empty = 1 and spaces_free = CAPACITY. Internal counters are also cleared.
- Reset asserted mid-operation aborts any OPEN or HOLD state and zeroes occupancy on the next edge.
- Sensor rising at edge N: gate_open goes high after edge N (1 cycle of latency).
- Passed pulse sampled at edge N:
  - occupancy, spaces_free, lot_full, lot_empty and error flags update after edge N.
  - The gate enters HOLD after edge N.
  - gate_open falls after edge N+CLOSE_DELAY.
- lot_full, lot_empty and spaces_free are decoded combinationally from the occupancy register, with no extra latency.

## Configuration
- GATE_TIMEOUT_EN defined:
  - Each gate has a cycle counter that is cleared on entry to OPEN and increments while in OPEN.
  - When the counter reaches GATE_TIMEOUT−1 with no passed pulse, the gate goes OPEN → CLOSED on the next edge and err_timeout is set.
  - If a passed pulse arrives in the same cycle, it takes priority (OPEN → HOLD, no error).
- GATE_TIMEOUT_EN undefined:
  - The timeout counter logic is absent.
  - OPEN persists until the passed pulse.
  - err_timeout is tied to 0.

## Test plan
- Reset then idle: occupancy=0, lot_empty=1, spaces_free=8, both gates 0.
- Entry sequence: entry_sensor=1 at edge 10 → entry_gate_open=1 after edge 10. entry_passed at edge 15 → occupancy=1 after edge 15, gate drops after edge 18.
- Fill to 8 vehicles, then assert entry_sensor → gate stays 0 and lot_full=1. A further entry_passed → occupancy stays 8 and err_overflow=1. clear_err → flag 0.
- Simultaneous entry_passed and exit_passed at occupancy=3 → occupancy stays 3, no error. exit_passed at occupancy=0 → occupancy stays 0, err_underflow=1.
- Reset_n low while the entry gate is in HOLD with occupancy=5 → after one edge: gate 0, occupancy 0, lot_empty 1.
- With GATE_TIMEOUT_EN: open the exit gate and send no pulse → gate closes after 50 cycles and err_timeout=1. Without the macro the gate stays open for more than 100 cycles.
